// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider.
//   ch_state_e : per-channel run state (STOP / RUN)
//   half_of    : half-period in input clocks for a wanted output frequency
//   CH_IDX_W   : width of a channel index (never less than 1 bit)
package clk_div_pkg;

    typedef enum logic {
        CH_STOP = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

    localparam int MAX_CH = 16;

    function automatic int half_of(input int freq_in, input int freq_out);
        return freq_in / (2 * freq_out);
    endfunction

    function automatic int CH_IDX_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/module_clk_div_ch.sv
// One divider channel: counts clk cycles up to half-1, toggles clk_out at
// each wrap, and pulses tick for one cycle whenever clk_out rises.
// A new half-period is held in pend_half until the channel reaches a point
// where swapping it in cannot shorten a half-period already in progress.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   en          run enable (0 = STOP, 1 = RUN)
//   sync        restart the phase of a running channel (count and clk_out to 0)
//   load        accept load_half as the pending half-period
//   load_half   new half-period, never 0 (filtered by the top)
//   clk_out     divided square wave
//   tick        one-cycle pulse in the first cycle clk_out is high
//   pending     a loaded value is waiting to be applied
module module_clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int               CNT_W    = 25,
    parameter logic [CNT_W-1:0] DEF_HALF = CNT_W'(13_500)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             load,
    input  logic [CNT_W-1:0] load_half,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ch_state_e        state, next_state;
    logic [CNT_W-1:0] count, count_nxt;
    logic [CNT_W-1:0] half, half_nxt;
    logic [CNT_W-1:0] pend_half, pend_half_nxt;
    logic [CNT_W-1:0] last;
    logic             pending_nxt;
    logic             clk_out_nxt;
    logic             tick_nxt;
    logic             wrap;

    // State and datapath registers; everything returns to the default
    // divide ratio with outputs low when reset is sampled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= CH_STOP;
            count     <= '0;
            half      <= DEF_HALF;
            pend_half <= DEF_HALF;
            pending   <= 1'b0;
            clk_out   <= 1'b0;
            tick      <= 1'b0;
        end else begin
            state     <= next_state;
            count     <= count_nxt;
            half      <= half_nxt;
            pend_half <= pend_half_nxt;
            pending   <= pending_nxt;
            clk_out   <= clk_out_nxt;
            tick      <= tick_nxt;
        end
    end

    // Next-state and datapath. en is looked at directly so the first wrap
    // after en rises lands exactly half edges later: the STOP->RUN edge
    // already counts as the first step from zero.
    always_comb begin
        next_state    = state;
        count_nxt     = count;
        half_nxt      = half;
        pend_half_nxt = pend_half;
        pending_nxt   = pending;
        clk_out_nxt   = clk_out;
        tick_nxt      = 1'b0;
        wrap          = 1'b0;
        last          = half - ONE;

        case (state)
            CH_STOP: begin
                count_nxt   = '0;
                clk_out_nxt = 1'b0;
                if (en) begin
                    next_state = CH_RUN;
                    wrap       = (last == '0);
                    count_nxt  = wrap ? '0 : ONE;
                end
            end
            CH_RUN: begin
                if (!en) begin
                    next_state  = CH_STOP;
                    count_nxt   = '0;
                    clk_out_nxt = 1'b0;
                end else begin
                    wrap      = (count == last);
                    count_nxt = wrap ? '0 : count + ONE;
                end
            end
            default: begin
                next_state  = CH_STOP;
                count_nxt   = '0;
                clk_out_nxt = 1'b0;
            end
        endcase

        if (wrap) begin
            clk_out_nxt = ~clk_out;
            tick_nxt    = ~clk_out;
        end

        // A phase restart overrides the wrap happening in the same cycle.
        if (sync && en) begin
            count_nxt   = '0;
            clk_out_nxt = 1'b0;
            tick_nxt    = 1'b0;
        end

        // Swap in the pending ratio only where no half-period is cut short:
        // at a wrap, at a phase restart, or while stopped.
        if (pending && (!en || wrap || sync)) begin
            half_nxt    = pend_half;
            pending_nxt = 1'b0;
        end

        // The top only loads when pending is clear, so this never collides
        // with the apply above.
        if (load) begin
            pend_half_nxt = load_half;
            pending_nxt   = 1'b1;
        end
    end

endmodule

// File: rtl/module_clk_div_multi.sv
// N-channel programmable clock divider / tick generator.
// Each channel produces f_clk/(2*HALF) on clk_out[i] and a one-cycle tick[i]
// on each rising edge. HALF is loaded per channel over a valid/ready port and
// takes effect without runt pulses.
// Optional feature: define FREQ_DIV_SYNC_EN to add the sync_i input, which
// restarts all running channels in phase.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   sync_i      (FREQ_DIV_SYNC_EN only) phase-align running channels
//   en          per-channel run enable
//   cfg_valid   config request
//   cfg_ready   channel cfg_ch can take a new value (combinational)
//   cfg_ch      target channel
//   cfg_half    new half-period in clk cycles
//   cfg_err     one-cycle pulse after a rejected request (half 0 or bad channel)
//   clk_out     divided square waves
//   tick        one-cycle pulse when clk_out[i] rises
module module_clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int  N_CH     = 4,
    parameter int  CNT_W    = 25,
    parameter int  FREQ_IN  = 27_000_000,
    parameter int  FREQ_OUT = 1_000,
    parameter int  DEF_HALF = half_of(FREQ_IN, FREQ_OUT),
    localparam int CH_W     = CH_IDX_W(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef FREQ_DIV_SYNC_EN
    input  logic             sync_i,
`endif
    input  logic [N_CH-1:0]  en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_err,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick
);

    localparam logic [CNT_W-1:0] DEF_HALF_W = CNT_W'(DEF_HALF);

    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] load;
    logic            ch_ok;
    logic            half_ok;
    logic            accept;
    logic            err_nxt;
    logic            ch_sync;

`ifdef FREQ_DIV_SYNC_EN
    assign ch_sync = sync_i;
`else
    assign ch_sync = 1'b0;
`endif

    // Config decode. An out-of-range channel has nothing pending to wait on,
    // so it reports ready and the request is consumed as an error.
    always_comb begin
        cfg_ready = 1'b1;
        load      = '0;
        ch_ok     = (int'(cfg_ch) < N_CH);
        half_ok   = (cfg_half != '0);
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pending[i];
            end
        end
        accept  = cfg_valid && cfg_ready;
        err_nxt = accept && !(ch_ok && half_ok);
        for (int i = 0; i < N_CH; i++) begin
            load[i] = accept && ch_ok && half_ok && (cfg_ch == CH_W'(i));
        end
    end

    // Error flag is registered so it appears the cycle after the request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= err_nxt;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        module_clk_div_ch #(
            .CNT_W   (CNT_W),
            .DEF_HALF(DEF_HALF_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en[g]),
            .sync     (ch_sync),
            .load     (load[g]),
            .load_half(cfg_half),
            .clk_out  (clk_out[g]),
            .tick     (tick[g]),
            .pending  (pending[g])
        );
    end

endmodule

// File: tb/tb_module_clk_div_multi.sv
// Directed testbench for module_clk_div_multi (N_CH=4, CNT_W=8, DEF_HALF=3).
// Edge k means the k-th rising clk after the stimulus was applied; outputs
// are sampled 1 time unit after that edge.
module tb_module_clk_div_multi;

    logic       clk;
    logic       rst_n;
    logic [3:0] en;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_half;
    logic       cfg_err;
    logic [3:0] clk_out;
    logic [3:0] tick;
`ifdef FREQ_DIV_SYNC_EN
    logic       sync_i;
`endif

    int n_vec = 0;
    int n_err = 0;

    module_clk_div_multi #(
        .N_CH    (4),
        .CNT_W   (8),
        .FREQ_IN (6_000),
        .FREQ_OUT(1_000),
        .DEF_HALF(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef FREQ_DIV_SYNC_EN
        .sync_i   (sync_i),
`endif
        .en       (en),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_half (cfg_half),
        .cfg_err  (cfg_err),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_half = '0;
`ifdef FREQ_DIV_SYNC_EN
        sync_i = 1'b0;
`endif
        step(); step();
        n_vec++;
        if (clk_out !== 4'b0000 || tick !== 4'b0000) begin
            n_err++; $display("[TB] FAIL reset_out clk_out=%b tick=%b want 0000/0000", clk_out, tick);
        end
        n_vec++;
        if (cfg_err !== 1'b0 || cfg_ready !== 1'b1) begin
            n_err++; $display("[TB] FAIL reset_cfg err=%b ready=%b want 0/1", cfg_err, cfg_ready);
        end
        rst_n = 1'b1;
        step();
        n_vec++;
        if (clk_out !== 4'b0000) begin
            n_err++; $display("[TB] FAIL idle_out clk_out=%b want 0000", clk_out);
        end
    endtask

    // ch0 at HALF=3: rises at edges 3,9,15, high for three edges each time.
    task automatic test_basic();
        logic [15:0] exp_clk;
        logic [15:0] exp_tick;
        exp_clk  = 16'hC71C;
        exp_tick = 16'h4104;
        en = 4'b0001;
        for (int k = 1; k <= 16; k++) begin
            step();
            n_vec++;
            if (clk_out !== {3'b000, exp_clk[k-1]}) begin
                n_err++; $display("[TB] FAIL basic_clk edge %0d got %b want %b", k, clk_out, {3'b000, exp_clk[k-1]});
            end
            n_vec++;
            if (tick !== {3'b000, exp_tick[k-1]}) begin
                n_err++; $display("[TB] FAIL basic_tick edge %0d got %b want %b", k, tick, {3'b000, exp_tick[k-1]});
            end
        end
        en = 4'b0000;
        step();
        n_vec++;
        if (clk_out !== 4'b0000) begin
            n_err++; $display("[TB] FAIL basic_stop got %b want 0000", clk_out);
        end
    endtask

    // ch1 loads HALF=5 at edge 2; the half-period ending at edge 3 is kept,
    // then high through edge 7, low 8..12, rising again at 13.
    task automatic test_reload();
        logic [11:0] exp_clk;
        logic [11:0] exp_tick;
        exp_clk  = 12'hC1F;
        exp_tick = 12'h401;
        en = 4'b0010;
        step();
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_half = 8'd5;
        #1;
        n_vec++;
        if (cfg_ready !== 1'b1) begin
            n_err++; $display("[TB] FAIL reload_ready_pre got %b want 1", cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
        #1;
        n_vec++;
        if (cfg_ready !== 1'b0) begin
            n_err++; $display("[TB] FAIL reload_ready_pending got %b want 0", cfg_ready);
        end
        n_vec++;
        if (clk_out !== 4'b0000) begin
            n_err++; $display("[TB] FAIL reload_clk edge 2 got %b want 0000", clk_out);
        end
        for (int k = 3; k <= 14; k++) begin
            step();
            if (k == 3) begin
                n_vec++;
                if (cfg_ready !== 1'b1) begin
                    n_err++; $display("[TB] FAIL reload_ready_applied got %b want 1", cfg_ready);
                end
            end
            n_vec++;
            if (clk_out !== {2'b00, exp_clk[k-3], 1'b0}) begin
                n_err++; $display("[TB] FAIL reload_clk edge %0d got %b want %b", k, clk_out, {2'b00, exp_clk[k-3], 1'b0});
            end
            n_vec++;
            if (tick !== {2'b00, exp_tick[k-3], 1'b0}) begin
                n_err++; $display("[TB] FAIL reload_tick edge %0d got %b want %b", k, tick, {2'b00, exp_tick[k-3], 1'b0});
            end
        end
        en = 4'b0000;
        step();
    endtask

    task automatic test_cfg_err();
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_half = 8'd0;
        #1;
        n_vec++;
        if (cfg_ready !== 1'b1) begin
            n_err++; $display("[TB] FAIL err_ready_pre got %b want 1", cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
        n_vec++;
        if (cfg_err !== 1'b1) begin
            n_err++; $display("[TB] FAIL err_pulse got %b want 1", cfg_err);
        end
        #1;
        n_vec++;
        if (cfg_ready !== 1'b1) begin
            n_err++; $display("[TB] FAIL err_no_pending got %b want 1", cfg_ready);
        end
        step();
        n_vec++;
        if (cfg_err !== 1'b0) begin
            n_err++; $display("[TB] FAIL err_one_cycle got %b want 0", cfg_err);
        end
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_half = 8'd0;
        step();
        cfg_valid = 1'b0;
        n_vec++;
        if (cfg_err !== 1'b1) begin
            n_err++; $display("[TB] FAIL err_pulse_ch3 got %b want 1", cfg_err);
        end
        step();
        n_vec++;
        if (cfg_err !== 1'b0) begin
            n_err++; $display("[TB] FAIL err_clear_ch3 got %b want 0", cfg_err);
        end
    endtask

    // ch2 still at HALF=3 (the rejected request changed nothing), so it rises
    // at edge 3 where HALF=1 takes over: toggling every edge, tick at 3,5,7,9.
    task automatic test_half1();
        logic [9:0] exp_hi;
        exp_hi = 10'h154;
        en = 4'b0100;
        for (int k = 1; k <= 10; k++) begin
            step();
            n_vec++;
            if (clk_out !== {1'b0, exp_hi[k-1], 2'b00}) begin
                n_err++; $display("[TB] FAIL half1_clk edge %0d got %b want %b", k, clk_out, {1'b0, exp_hi[k-1], 2'b00});
            end
            n_vec++;
            if (tick !== {1'b0, exp_hi[k-1], 2'b00}) begin
                n_err++; $display("[TB] FAIL half1_tick edge %0d got %b want %b", k, tick, {1'b0, exp_hi[k-1], 2'b00});
            end
            if (k == 1) begin
                cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_half = 8'd1;
            end
            if (k == 2) begin
                cfg_valid = 1'b0;
                #1;
                n_vec++;
                if (cfg_err !== 1'b0 || cfg_ready !== 1'b0) begin
                    n_err++; $display("[TB] FAIL half1_accept err=%b ready=%b want 0/0", cfg_err, cfg_ready);
                end
            end
            if (k == 3) begin
                n_vec++;
                if (cfg_ready !== 1'b1) begin
                    n_err++; $display("[TB] FAIL half1_applied ready=%b want 1", cfg_ready);
                end
            end
        end
        en = 4'b0000;
        step();
        n_vec++;
        if (clk_out !== 4'b0000) begin
            n_err++; $display("[TB] FAIL half1_stop got %b want 0000", clk_out);
        end
    endtask

    // ch0 HALF=3 would rise at edge 9; en drops just before it, with HALF=2
    // pending. STOP wins, the pending value is applied, and a restart shows it.
    task automatic test_en_drop_on_wrap();
        en = 4'b0001; cfg_ch = 2'd0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 3) begin
                n_vec++;
                if (clk_out !== 4'b0001 || tick !== 4'b0001) begin
                    n_err++; $display("[TB] FAIL drop_rise clk_out=%b tick=%b want 0001/0001", clk_out, tick);
                end
            end
            if (k == 6) begin
                n_vec++;
                if (clk_out !== 4'b0000) begin
                    n_err++; $display("[TB] FAIL drop_fall clk_out=%b want 0000", clk_out);
                end
            end
            if (k == 7) begin
                cfg_valid = 1'b1; cfg_half = 8'd2;
            end
            if (k == 8) begin
                cfg_valid = 1'b0; en = 4'b0000;
                #1;
                n_vec++;
                if (cfg_ready !== 1'b0) begin
                    n_err++; $display("[TB] FAIL drop_pending ready=%b want 0", cfg_ready);
                end
            end
        end
        step();
        n_vec++;
        if (clk_out !== 4'b0000 || tick !== 4'b0000) begin
            n_err++; $display("[TB] FAIL drop_on_wrap clk_out=%b tick=%b want 0000/0000", clk_out, tick);
        end
        n_vec++;
        if (cfg_ready !== 1'b1) begin
            n_err++; $display("[TB] FAIL drop_applied ready=%b want 1", cfg_ready);
        end
        en = 4'b0001;
        step();
        n_vec++;
        if (clk_out !== 4'b0000) begin
            n_err++; $display("[TB] FAIL drop_half2_e1 clk_out=%b want 0000", clk_out);
        end
        step();
        n_vec++;
        if (clk_out !== 4'b0001 || tick !== 4'b0001) begin
            n_err++; $display("[TB] FAIL drop_half2_e2 clk_out=%b tick=%b want 0001/0001", clk_out, tick);
        end
    endtask

    task automatic test_reset_mid_run();
        en = 4'b0011;
        step(); step();
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_half = 8'd7;
        step();
        cfg_valid = 1'b0;
        #1;
        n_vec++;
        if (cfg_ready !== 1'b0) begin
            n_err++; $display("[TB] FAIL rst_pending_before ready=%b want 0", cfg_ready);
        end
        rst_n = 1'b0; en = 4'b0000;
        step();
        n_vec++;
        if (clk_out !== 4'b0000 || tick !== 4'b0000 || cfg_err !== 1'b0) begin
            n_err++; $display("[TB] FAIL rst_mid_out clk_out=%b tick=%b err=%b want 0000/0000/0", clk_out, tick, cfg_err);
        end
        n_vec++;
        if (cfg_ready !== 1'b1) begin
            n_err++; $display("[TB] FAIL rst_mid_pending ready=%b want 1", cfg_ready);
        end
        step();
        rst_n = 1'b1; en = 4'b0011;
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k < 3) begin
                n_vec++;
                if (clk_out !== 4'b0000) begin
                    n_err++; $display("[TB] FAIL rst_def_half edge %0d clk_out=%b want 0000", k, clk_out);
                end
            end else begin
                n_vec++;
                if (clk_out !== 4'b0011 || tick !== 4'b0011) begin
                    n_err++; $display("[TB] FAIL rst_def_half edge 3 clk_out=%b tick=%b want 0011/0011", clk_out, tick);
                end
            end
        end
    endtask

`ifdef FREQ_DIV_SYNC_EN
    // ch0 starts one edge before ch1; sync lands on ch0's would-be wrap,
    // which is suppressed, and both then rise together three edges later.
    task automatic test_sync();
        en = 4'b0000;
        step();
        en = 4'b0001;
        step();
        en = 4'b0011;
        step();
        sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        n_vec++;
        if (clk_out !== 4'b0000 || tick !== 4'b0000) begin
            n_err++; $display("[TB] FAIL sync_edge clk_out=%b tick=%b want 0000/0000", clk_out, tick);
        end
        step(); step();
        n_vec++;
        if (clk_out !== 4'b0000) begin
            n_err++; $display("[TB] FAIL sync_wait clk_out=%b want 0000", clk_out);
        end
        step();
        n_vec++;
        if (clk_out !== 4'b0011 || tick !== 4'b0011) begin
            n_err++; $display("[TB] FAIL sync_aligned clk_out=%b tick=%b want 0011/0011", clk_out, tick);
        end
    endtask
`endif

    initial begin
        $display("[TB] start");
        test_reset();
        test_basic();
        test_reload();
        test_cfg_err();
        test_half1();
        test_en_drop_on_wrap();
        test_reset_mid_run();
`ifdef FREQ_DIV_SYNC_EN
        test_sync();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
